// File: rtl/harvard_loader_pkg.sv
// SystemPeripheral_Pkg: shared bus types plus loader state, error and register-offset definitions
package SystemPeripheral_Pkg;
  typedef struct packed {
    logic [7:0]  raddr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
  } sys_peripheral_t;
  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;
  typedef enum logic [3:0] {
    LD_IDLE, LD_SYNC, LD_ADDR0, LD_ADDR1, LD_LEN0, LD_LEN1, LD_DATA, LD_CSUM, LD_DONE, LD_ERROR
  } loader_state_e;
  typedef enum logic [1:0] {E_NONE, E_TIMEOUT, E_RANGE, E_CSUM} loader_err_e;
  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] LOADER_CTRL = 8'd0;
  localparam logic [7:0] LOADER_COUNT = 8'd1;
  localparam logic [7:0] LOADER_CSUM = 8'd2;
endpackage

// File: rtl/harvard_loader_byte_timer.sv
// loader_byte_timer: inter-byte idle watchdog, expired pulses after TIMEOUT cycles without reload
module loader_byte_timer #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic hb_clk,
  input  logic rst_n,
  input  logic reload,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  assign expired = run && !reload && cnt == LAST;
  always_ff @(posedge hb_clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!run || reload || expired) ? '0 : cnt + W'(1);
endmodule

// File: rtl/harvard_loader.sv
// harvard_loader: framed UART image loader into instruction RAM; HARVARD_LOADER_CHECKSUM_EN adds the trailing checksum byte
module harvard_loader
  import SystemPeripheral_Pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              hb_clk,
  input  logic              rst_n,
  input  sys_peripheral_t   sys_share,
  input  sel_t              sel,
  output logic [31:0]       rdata,
  input  logic              download_mode,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              iram_we,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [31:0]       iram_wdata
);
  loader_state_e state, state_n;
  loader_err_e err, err_n;
  logic [ADDR_W-1:0] ptr, len, wcnt, cap;
  logic [7:0] lo;
  logic [23:0] word;
  logic [1:0] bidx;
  logic [31:0] csum_rd;
  logic ctrl_wr, busy, run, abort, arm, take, wr_word, last, range_bad, expired;
  logic unused_wdata;
`ifdef HARVARD_LOADER_CHECKSUM_EN
  localparam loader_state_e TAIL = LD_CSUM;
  logic [7:0] csum;
  assign csum_rd = 32'(csum);
`else
  localparam loader_state_e TAIL = LD_DONE;
  assign csum_rd = '0;
`endif
  assign unused_wdata = &{1'b0, sys_share.wdata[31:2]};
  assign ctrl_wr = sel.wen && sys_share.waddr == LOADER_CTRL;
  assign busy = state >= LD_SYNC && state <= LD_CSUM;
  assign run = state >= LD_ADDR0 && state <= LD_CSUM;
  assign abort = (ctrl_wr && sys_share.wdata[1]) || (busy && !download_mode);
  assign arm = ctrl_wr && sys_share.wdata[0] && download_mode && !busy && !abort;
  // a control write in the same cycle wins and the byte is lost
  assign take = rx_valid && !ctrl_wr && !abort;
  assign cap = ADDR_W'({rx_data, lo});
  assign range_bad = {1'b0, ptr} + {1'b0, cap} > {1'b1, {ADDR_W{1'b0}}};
  assign wr_word = take && state == LD_DATA && bidx == 2'd3;
  assign last = wcnt + ADDR_W'(1) == len;
  loader_byte_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .hb_clk (hb_clk),
    .rst_n  (rst_n),
    .reload (rx_valid),
    .run    (run),
    .expired(expired)
  );
  always_comb begin
    state_n = state;
    err_n = err;
    if (abort) begin
      state_n = LD_IDLE;
      err_n = E_NONE;
    end else if (arm) begin
      state_n = LD_SYNC;
      err_n = E_NONE;
    end else if (expired) begin
      state_n = LD_ERROR;
      err_n = E_TIMEOUT;
    end else if (take) begin
      case (state)
        LD_SYNC:  state_n = rx_data == LOADER_SYNC_BYTE ? LD_ADDR0 : LD_SYNC;
        LD_ADDR0: state_n = LD_ADDR1;
        LD_ADDR1: state_n = LD_LEN0;
        LD_LEN0:  state_n = LD_LEN1;
        LD_LEN1: begin
          state_n = range_bad ? LD_ERROR : (cap == '0 ? TAIL : LD_DATA);
          err_n = range_bad ? E_RANGE : E_NONE;
        end
        LD_DATA:  state_n = wr_word && last ? TAIL : LD_DATA;
`ifdef HARVARD_LOADER_CHECKSUM_EN
        LD_CSUM: begin
          state_n = rx_data == csum ? LD_DONE : LD_ERROR;
          err_n = rx_data == csum ? E_NONE : E_CSUM;
        end
`endif
        default: ;
      endcase
    end
  end
  always_ff @(posedge hb_clk or negedge rst_n)
    if (!rst_n) begin
      state <= LD_IDLE;
      err <= E_NONE;
    end else begin
      state <= state_n;
      err <= err_n;
    end
  always_ff @(posedge hb_clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      len <= '0;
      wcnt <= '0;
      lo <= '0;
      word <= '0;
      bidx <= '0;
      iram_we <= 1'b0;
      iram_addr <= '0;
      iram_wdata <= '0;
    end else begin
      iram_we <= wr_word;
      if (abort || arm) begin
        ptr <= '0;
        len <= '0;
        wcnt <= '0;
        bidx <= '0;
      end else if (take) begin
        if (state == LD_ADDR0 || state == LD_LEN0) lo <= rx_data;
        if (state == LD_ADDR1) ptr <= cap;
        if (state == LD_LEN1) len <= cap;
        if (state == LD_DATA) begin
          word <= {rx_data, word[23:8]};
          bidx <= bidx + 2'd1;
        end
        if (wr_word) begin
          iram_addr <= ptr;
          iram_wdata <= {rx_data, word};
          ptr <= ptr + ADDR_W'(1);
          wcnt <= wcnt + ADDR_W'(1);
        end
      end
    end
`ifdef HARVARD_LOADER_CHECKSUM_EN
  always_ff @(posedge hb_clk or negedge rst_n)
    if (!rst_n) csum <= '0;
    else if (abort || arm) csum <= '0;
    else if (take && state == LD_DATA) csum <= csum + rx_data;
`endif
  always_ff @(posedge hb_clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (sel.ren)
      rdata <= sys_share.raddr == LOADER_CTRL  ? {20'b0, state, 2'b0, err, 2'b0, busy, state == LD_DONE} :
               sys_share.raddr == LOADER_COUNT ? 32'(wcnt) :
               sys_share.raddr == LOADER_CSUM  ? csum_rd : '0;
endmodule

// File: tb/tb_harvard_loader.sv
// tb_harvard_loader: directed and randomized frames checked against a frame-level reference model
module tb_harvard_loader;
  import SystemPeripheral_Pkg::*;
  localparam int AW = 12;
  localparam int TO = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  sys_peripheral_t share;
  sel_t sel;
  logic [31:0] rdata, iram_wdata;
  logic download_mode, rx_valid, iram_we;
  logic [7:0] rx_data;
  logic [AW-1:0] iram_addr;
  int vectors = 0, miscompares = 0;
  logic [43:0] obs_q[$], exp_q[$];
  logic [7:0] dat[$];
  always #5 clk = ~clk;
  harvard_loader #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .hb_clk       (clk),
    .rst_n        (rst_n),
    .sys_share    (share),
    .sel          (sel),
    .rdata        (rdata),
    .download_mode(download_mode),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .iram_we      (iram_we),
    .iram_addr    (iram_addr),
    .iram_wdata   (iram_wdata)
  );
  always @(negedge clk) if (iram_we) obs_q.push_back({iram_addr, iram_wdata});
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ctrl(input loader_state_e s, input loader_err_e e);
    return {20'b0, s, 2'b0, e, 2'b0, s >= LD_SYNC && s <= LD_CSUM, s == LD_DONE};
  endfunction
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask
  task automatic wr(input logic [31:0] d);
    sel.wen = 1'b1;
    share.waddr = LOADER_CTRL;
    share.wdata = d;
    @(posedge clk);
    #1 sel.wen = 1'b0;
  endtask
  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    sel.ren = 1'b1;
    share.raddr = off;
    @(posedge clk);
    #1 sel.ren = 1'b0;
    r = rdata;
  endtask
  task automatic hdr(input logic [15:0] a, input logic [15:0] n);
    send(LOADER_SYNC_BYTE);
    send(a[7:0]);
    send(a[15:8]);
    send(n[7:0]);
    send(n[15:8]);
  endtask
  // model: truncate fields, range-check, expect one little-endian word per 4 data bytes
  task automatic frame(input logic [15:0] a, input logic [15:0] n, input bit bad, input int junk, input int gap);
    int aa, nn;
    bit rng;
    logic [7:0] cs, j;
    logic [31:0] r;
    loader_state_e es;
    loader_err_e ee;
    aa = int'(a) % (1 << AW);
    nn = int'(n) % (1 << AW);
    rng = aa + nn > (1 << AW);
    cs = 8'd0;
    foreach (dat[i]) cs += dat[i];
    exp_q.delete();
    obs_q.delete();
    if (!rng)
      for (int k = 0; k < nn; k++)
        exp_q.push_back({AW'(aa + k), dat[4*k+3], dat[4*k+2], dat[4*k+1], dat[4*k]});
    wr(32'h1);
    repeat (junk) begin
      j = 8'($urandom);
      send(j == LOADER_SYNC_BYTE ? 8'h00 : j);
    end
    hdr(a, n);
    if (!rng) begin
      foreach (dat[i]) begin
        tick($urandom_range(0, gap));
        send(dat[i]);
      end
      send(bad ? cs + 8'd1 : cs);
    end
    tick(3);
    check("write_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) check("write_word", i < obs_q.size() ? obs_q[i] : 'x, exp_q[i]);
`ifdef HARVARD_LOADER_CHECKSUM_EN
    es = (rng || bad) ? LD_ERROR : LD_DONE;
    ee = rng ? E_RANGE : (bad ? E_CSUM : E_NONE);
`else
    es = rng ? LD_ERROR : LD_DONE;
    ee = rng ? E_RANGE : E_NONE;
`endif
    rd(LOADER_CTRL, r);
    check("status", r, ctrl(es, ee));
    rd(LOADER_COUNT, r);
    check("words", r, rng ? 0 : nn);
    rd(LOADER_CSUM, r);
`ifdef HARVARD_LOADER_CHECKSUM_EN
    check("csum", r, rng ? 0 : cs);
`else
    check("csum", r, 0);
`endif
  endtask
  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: bench did not finish");
  end
  initial begin
    logic [31:0] r;
    logic [15:0] a, nw;
    share = '0;
    sel = '0;
    download_mode = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_we", iram_we, 0);
    check("rst_addr", iram_addr, 0);
    check("rst_wdata", iram_wdata, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(LOADER_CTRL, r);
    check("rst_status", r, ctrl(LD_IDLE, E_NONE));
    rd(LOADER_COUNT, r);
    check("rst_words", r, 0);
    wr(32'h1);
    rd(LOADER_CTRL, r);
    check("arm_no_mode", r, ctrl(LD_IDLE, E_NONE));
    rd(8'd7, r);
    check("bad_offset", r, 0);
    download_mode = 1'b1;
    dat = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    frame(16'h0010, 16'h0002, 1'b0, 0, 0);
    check("normal_w0", obs_q.size() > 0 ? obs_q[0] : 'x, {12'h010, 32'h12345678});
    check("normal_w1", obs_q.size() > 1 ? obs_q[1] : 'x, {12'h011, 32'hDEADBEEF});
    wr(32'h1);
    rd(LOADER_COUNT, r);
    check("rearm_words", r, 0);
    rd(LOADER_CTRL, r);
    check("rearm_status", r, ctrl(LD_SYNC, E_NONE));
    dat.delete();
    frame(16'h0123, 16'h0000, 1'b0, 3, 0);
    frame(16'h0FFF, 16'h0002, 1'b0, 0, 0);
    dat.delete();
    repeat (8) dat.push_back(8'($urandom));
    frame(16'hFFFE, 16'h0002, 1'b0, 0, 0);
    dat = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    frame(16'h0010, 16'h0002, 1'b1, 0, 0);
    wr(32'h1);
    obs_q.delete();
    hdr(16'h0000, 16'h0002);
    send(8'h11);
    send(8'h22);
    tick(TO - 1);
    rd(LOADER_CTRL, r);
    check("timeout_before", r, ctrl(LD_DATA, E_NONE));
    rd(LOADER_CTRL, r);
    check("timeout_after", r, ctrl(LD_ERROR, E_TIMEOUT));
    check("timeout_nowrite", obs_q.size(), 0);
    wr(32'h1);
    obs_q.delete();
    hdr(16'h0020, 16'h0001);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    rx_valid = 1'b1;
    rx_data = 8'h66;
    sel.wen = 1'b1;
    share.waddr = LOADER_CTRL;
    share.wdata = 32'h2;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    sel.wen = 1'b0;
    tick(2);
    rd(LOADER_CTRL, r);
    check("abort_status", r, ctrl(LD_IDLE, E_NONE));
    rd(LOADER_COUNT, r);
    check("abort_words", r, 0);
    rd(LOADER_CSUM, r);
    check("abort_csum", r, 0);
    check("abort_nowrite", obs_q.size(), 0);
    wr(32'h1);
    hdr(16'h0030, 16'h0001);
    send(8'h77);
    download_mode = 1'b0;
    tick(1);
    download_mode = 1'b1;
    rd(LOADER_CTRL, r);
    check("mode_drop", r, ctrl(LD_IDLE, E_NONE));
    wr(32'h1);
    obs_q.delete();
    hdr(16'h0040, 16'h0002);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    check("pre_rst_we", iram_we, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", iram_we, 0);
    #1 rst_n = 1'b1;
    rd(LOADER_CTRL, r);
    check("rst_mid_status", r, ctrl(LD_IDLE, E_NONE));
    rd(LOADER_COUNT, r);
    check("rst_mid_words", r, 0);
    check("rst_mid_nowrite", obs_q.size(), 0);
    for (int t = 0; t < 8; t++) begin
      nw = {4'($urandom), 12'($urandom_range(0, 3))};
      a = {4'($urandom), 12'($urandom_range(0, 4095))};
      dat.delete();
      for (int i = 0; i < 4 * int'(nw[11:0]); i++) dat.push_back(8'($urandom));
      frame(a, nw, 1'($urandom), $urandom_range(0, 3), 4);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
